// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one physical memory port between instruction fetch (A) and mem-stage data (B).
// Optional feature: define MEM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking (default: B always wins ties).
module mem_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             read_a,
    input  logic             write_a,
    input  logic [1:0]       wmask_a,
    input  logic [WIDTH-1:0] address_a,
    input  logic [WIDTH-1:0] wdata_a,
    output logic             resp_a,
    output logic [WIDTH-1:0] rdata_a,
    input  logic             read_b,
    input  logic             write_b,
    input  logic [1:0]       wmask_b,
    input  logic [WIDTH-1:0] address_b,
    input  logic [WIDTH-1:0] wdata_b,
    output logic             resp_b,
    output logic [WIDTH-1:0] rdata_b,
    output logic             pmem_read,
    output logic             pmem_write,
    output logic [1:0]       pmem_wmask,
    output logic [WIDTH-1:0] pmem_address,
    output logic [WIDTH-1:0] pmem_wdata,
    input  logic             pmem_resp,
    input  logic [WIDTH-1:0] pmem_rdata,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_A = 2'd1,
        SERVE_B = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             pmem_read_q, pmem_read_d;
    logic             pmem_write_q, pmem_write_d;
    logic [1:0]       pmem_wmask_q, pmem_wmask_d;
    logic [WIDTH-1:0] pmem_address_q, pmem_address_d;
    logic [WIDTH-1:0] pmem_wdata_q, pmem_wdata_d;
    logic             busy_q, busy_d;

    logic             req_a_s, req_b_s;
    logic             grant_a_s, grant_b_s;
    logic             sel_read_s, sel_write_s;
    logic [1:0]       sel_wmask_s;
    logic [WIDTH-1:0] sel_address_s, sel_wdata_s;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // 1 means port B was granted most recently; reset value says A went last.
    logic             last_served_q, last_served_d;
`endif

    assign req_a_s = read_a | write_a;
    assign req_b_s = read_b | write_b;

    // Grant decision in IDLE; ties resolved by the configured priority rule.
    always_comb begin
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
        if (state_q == IDLE) begin
            if (req_a_s && !req_b_s) begin
                grant_a_s = 1'b1;
            end else if (req_b_s && !req_a_s) begin
                grant_b_s = 1'b1;
            end else if (req_a_s && req_b_s) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                if (last_served_q) begin
                    grant_a_s = 1'b1;
                end else begin
                    grant_b_s = 1'b1;
                end
`else
                grant_b_s = 1'b1;
`endif
            end else begin
                grant_a_s = 1'b0;
                grant_b_s = 1'b0;
            end
        end else begin
            grant_a_s = 1'b0;
            grant_b_s = 1'b0;
        end
    end

    // Winner's request fields, selected for latching on the grant edge.
    always_comb begin
        if (grant_b_s) begin
            sel_read_s    = read_b;
            sel_write_s   = write_b;
            sel_wmask_s   = wmask_b;
            sel_address_s = address_b;
            sel_wdata_s   = wdata_b;
        end else begin
            sel_read_s    = read_a;
            sel_write_s   = write_a;
            sel_wmask_s   = wmask_a;
            sel_address_s = address_a;
            sel_wdata_s   = wdata_a;
        end
    end

    // Next-state and pmem request register update.
    always_comb begin
        state_d        = state_q;
        pmem_read_d    = pmem_read_q;
        pmem_write_d   = pmem_write_q;
        pmem_wmask_d   = pmem_wmask_q;
        pmem_address_d = pmem_address_q;
        pmem_wdata_d   = pmem_wdata_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_served_d  = last_served_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant_a_s || grant_b_s) begin
                    state_d        = grant_b_s ? SERVE_B : SERVE_A;
                    // Write takes precedence when both strobes are set.
                    pmem_write_d   = sel_write_s;
                    pmem_read_d    = sel_read_s & ~sel_write_s;
                    pmem_wmask_d   = sel_wmask_s;
                    pmem_address_d = sel_address_s;
                    pmem_wdata_d   = sel_wdata_s;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    last_served_d  = grant_b_s;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            SERVE_A, SERVE_B: begin
                if (pmem_resp) begin
                    state_d      = IDLE;
                    pmem_read_d  = 1'b0;
                    pmem_write_d = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d      = IDLE;
                pmem_read_d  = 1'b0;
                pmem_write_d = 1'b0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            pmem_read_q    <= 1'b0;
            pmem_write_q   <= 1'b0;
            pmem_wmask_q   <= 2'b00;
            pmem_address_q <= '0;
            pmem_wdata_q   <= '0;
            busy_q         <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_served_q  <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            pmem_read_q    <= pmem_read_d;
            pmem_write_q   <= pmem_write_d;
            pmem_wmask_q   <= pmem_wmask_d;
            pmem_address_q <= pmem_address_d;
            pmem_wdata_q   <= pmem_wdata_d;
            busy_q         <= busy_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_served_q  <= last_served_d;
`endif
        end
    end

    // Only the granted port sees the completion; pmem_resp in IDLE is dropped.
    assign resp_a       = (state_q == SERVE_A) & pmem_resp;
    assign resp_b       = (state_q == SERVE_B) & pmem_resp;
    assign rdata_a      = pmem_rdata;
    assign rdata_b      = pmem_rdata;
    assign pmem_read    = pmem_read_q;
    assign pmem_write   = pmem_write_q;
    assign pmem_wmask   = pmem_wmask_q;
    assign pmem_address = pmem_address_q;
    assign pmem_wdata   = pmem_wdata_q;
    assign busy         = busy_q;

endmodule
